// File: rtl/egress_port.sv
// Egress side of one switch output: a small circular buffer feeding a valid/ready link,
// with misroute/overflow drop accounting, a delivered-packet counter and a link-stall watchdog.
module egress_port #(
    parameter int PORT_ID      = 0,
    parameter int DEPTH        = 4,
    parameter int PACKET_WIDTH = 16,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [PACKET_WIDTH-1:0] in_data,
    output logic                    in_full,
    output logic                    link_valid,
    output logic [PACKET_WIDTH-1:0] link_data,
    input  logic                    link_ready,
    output logic                    misroute_err,
    output logic                    stall_err,
    output logic [7:0]              drop_cnt,
    output logic [15:0]             tx_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_reg, state_next;
    logic [PACKET_WIDTH-1:0] buffer [DEPTH];
    logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]           count_reg;
    logic [SW-1:0]           stall_cnt_reg;
    logic                    misroute_reg;
    logic [7:0]              drop_cnt_reg;
    logic [15:0]             tx_cnt_reg;

    logic target_ok, wr_en, drop_en, handshake;

    // Full is decoded from the registered count only, so a same-cycle pop never frees a slot.
    assign in_full    = (count_reg == CW'(DEPTH));
    assign target_ok  = in_data[PORT_ID];
    assign wr_en      = in_valid && !in_full && target_ok;
    assign drop_en    = in_valid && (!target_ok || in_full);
    assign link_valid = (state_reg == SEND);
    assign handshake  = link_valid && link_ready;
    assign link_data  = buffer[rd_ptr_reg];

    assign misroute_err = misroute_reg;
    assign stall_err    = (stall_cnt_reg == SW'(TIMEOUT));
    assign drop_cnt     = drop_cnt_reg;
    assign tx_cnt       = tx_cnt_reg;

    // Storage carries no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_ptr_reg] <= in_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (count_reg != '0) state_next = SEND;
            SEND: if (handshake && count_reg == CW'(1) && !wr_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            stall_cnt_reg <= '0;
            misroute_reg  <= 1'b0;
            drop_cnt_reg  <= '0;
            tx_cnt_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            misroute_reg <= in_valid && !target_ok;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (handshake) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                tx_cnt_reg <= tx_cnt_reg + 16'd1;
            end
            case ({wr_en, handshake})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop_en && drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
            // Watchdog saturates at TIMEOUT so stall_err stays up until the link moves.
            if (state_reg == IDLE || handshake) begin
                stall_cnt_reg <= '0;
            end else if (stall_cnt_reg != SW'(TIMEOUT)) begin
                stall_cnt_reg <= stall_cnt_reg + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_egress_port.sv
// Scoreboarded bench for egress_port (PORT_ID=2): directed scenarios plus a random phase.
module tb_egress_port;
    localparam int PID = 2;
    localparam int DEPTH = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_full;
    logic        link_valid;
    logic [15:0] link_data;
    logic        link_ready;
    logic        misroute_err;
    logic        stall_err;
    logic [7:0]  drop_cnt;
    logic [15:0] tx_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic mon_en = 1'b0;

    egress_port #(.PORT_ID(PID), .DEPTH(DEPTH), .PACKET_WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_full(in_full), .link_valid(link_valid), .link_data(link_data),
        .link_ready(link_ready), .misroute_err(misroute_err), .stall_err(stall_err),
        .drop_cnt(drop_cnt), .tx_cnt(tx_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference model of the port, with the expected packet stream in sb.
    logic [15:0] sb[$];
    logic [2:0]  m_count;
    logic        m_state;
    logic [4:0]  m_stall;
    logic [7:0]  m_drop;
    logic [15:0] m_tx;
    logic        m_mis;
    logic m_full, m_wr, m_hs, m_drop_en;

    assign m_full    = (m_count == 3'(DEPTH));
    assign m_wr      = in_valid && !m_full && in_data[PID];
    assign m_hs      = m_state && link_ready;
    assign m_drop_en = in_valid && (!in_data[PID] || m_full);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= '0; m_state <= 1'b0; m_stall <= '0;
            m_drop <= '0; m_tx <= '0; m_mis <= 1'b0;
            sb.delete();
        end else begin
            if (m_wr) sb.push_back(in_data);
            m_count <= m_count + 3'(m_wr) - 3'(m_hs);
            if (!m_state) m_state <= (m_count != 0);
            else if (m_hs && m_count == 3'd1 && !m_wr) m_state <= 1'b0;
            m_stall <= (m_state && !link_ready) ? ((m_stall == 5'(TO)) ? m_stall : m_stall + 5'd1) : 5'd0;
            m_mis   <= in_valid && !in_data[PID];
            m_drop  <= m_drop + 8'((m_drop_en && m_drop != 8'hFF) ? 1 : 0);
            m_tx    <= m_tx + 16'(m_hs);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("link_valid", 32'(link_valid), 32'(m_state));
            check("in_full", 32'(in_full), 32'(m_full));
            check("misroute_err", 32'(misroute_err), 32'(m_mis));
            check("stall_err", 32'(stall_err), 32'(m_stall == 5'(TO)));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("tx_cnt", 32'(tx_cnt), 32'(m_tx));
            if (m_hs) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    logic [15:0] exp_pkt;
                    exp_pkt = sb.pop_front();
                    $display("tx pkt %04h expected %04h", link_data, exp_pkt);
                    check("link_data", 32'(link_data), 32'(exp_pkt));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; link_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        check("rst_valid", 32'(link_valid), 32'd0);
        check("rst_full", 32'(in_full), 32'd0);
        check("rst_tx", 32'(tx_cnt), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // Single packet, latency and return to IDLE.
        link_ready = 1'b1; in_valid = 1'b1; in_data = 16'h5A14;
        step();
        in_valid = 1'b0;
        check("lat_edge1_valid", 32'(link_valid), 32'd0);
        step();
        check("lat_edge2_valid", 32'(link_valid), 32'd1);
        check("lat_data", 32'(link_data), 32'h5A14);
        step();
        check("single_tx", 32'(tx_cnt), 32'd1);
        check("single_idle", 32'(link_valid), 32'd0);

        // Overflow: five back-to-back writes into four slots.
        link_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = {8'(8'h10 + i), 4'b0001, 4'b0100};
            step();
        end
        in_valid = 1'b0;
        check("ovf_full", 32'(in_full), 32'd1);
        check("ovf_drop", 32'(drop_cnt), 32'd1);
        link_ready = 1'b1;
        repeat (5) step();
        check("ovf_tx", 32'(tx_cnt), 32'd5);
        check("ovf_idle", 32'(link_valid), 32'd0);

        // Misrouted packet.
        in_valid = 1'b1; in_data = 16'h0011;
        step();
        in_valid = 1'b0;
        check("mis_pulse", 32'(misroute_err), 32'd1);
        check("mis_drop", 32'(drop_cnt), 32'd2);
        check("mis_valid", 32'(link_valid), 32'd0);
        step();
        check("mis_pulse_end", 32'(misroute_err), 32'd0);

        // Link stall watchdog.
        link_ready = 1'b0; in_valid = 1'b1; in_data = 16'h3314;
        step();
        in_valid = 1'b0;
        step();
        repeat (TO - 1) step();
        check("stall_before", 32'(stall_err), 32'd0);
        step();
        check("stall_hit", 32'(stall_err), 32'd1);
        check("stall_data", 32'(link_data), 32'h3314);
        step();
        check("stall_hold", 32'(stall_err), 32'd1);
        link_ready = 1'b1;
        step();
        check("stall_clear", 32'(stall_err), 32'd0);
        check("stall_tx", 32'(tx_cnt), 32'd6);

        // Full buffer: write and pop in the same cycle, write must be dropped.
        link_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = {8'(8'h60 + i), 4'b0010, 4'b0100};
            step();
        end
        in_valid = 1'b1; in_data = 16'h7724; link_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("fullpop_drop", 32'(drop_cnt), 32'd3);
        check("fullpop_notfull", 32'(in_full), 32'd0);
        repeat (4) step();
        check("fullpop_tx", 32'(tx_cnt), 32'd10);

        // Asynchronous reset with packets in flight.
        link_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = {8'(8'hA0 + i), 4'b1000, 4'b0100};
            step();
        end
        in_valid = 1'b0;
        step();
        check("prerst_valid", 32'(link_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(link_valid), 32'd0);
        check("arst_full", 32'(in_full), 32'd0);
        check("arst_tx", 32'(tx_cnt), 32'd0);
        check("arst_drop", 32'(drop_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("postrst_valid", 32'(link_valid), 32'd0);

        // Random traffic, checked continuously against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_data    = {8'($urandom), 4'($urandom), 4'($urandom)};
            link_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        in_valid = 1'b0; link_ready = 1'b1;
        repeat (10) step();
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_idle", 32'(link_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/egress_port.md
EGRESS_PORT -- requirements
Module: egress_port

Interface
REQ-001 Parameter PORT_ID, default 0: index (0-3) of the switch output this block terminates.
REQ-002 Parameter DEPTH, default 4: egress buffer entries, power of two, minimum 2.
REQ-003 Parameter PACKET_WIDTH, default 16: packet width; [7:4] source one-hot, [3:0] target one-hot, [15:8] payload.
REQ-004 Parameter TIMEOUT, default 16: link-stall threshold in cycles.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 in_valid  input  1  switch output mux presents a packet this cycle (qualified by the arbiter's active signal upstream).
REQ-008 in_data  input  PACKET_WIDTH  packet from the output mux.
REQ-009 in_full  output  1  backpressure to the arbiter; high when the buffer holds DEPTH entries.
REQ-010 link_valid  output  1  packet on link_data is valid.
REQ-011 link_data  output  PACKET_WIDTH  head-of-buffer packet.
REQ-012 link_ready  input  1  downstream accepts link_data this cycle.
REQ-013 misroute_err  output  1  one-cycle pulse: packet with in_data[PORT_ID]==0 was offered.
REQ-014 stall_err  output  1  link stalled for TIMEOUT cycles.
REQ-015 drop_cnt  output  8  packets dropped (full or misrouted), saturating at 255.
REQ-016 tx_cnt  output  16  packets delivered on the link, wraps at 65535->0.

Function
REQ-017 Write: in_valid && !in_full && in_data[PORT_ID]==1 SHALL store in_data at wr_ptr, increment wr_ptr (mod DEPTH) and count.
REQ-018 in_valid with in_data[PORT_ID]==0 SHALL not be stored; misroute_err pulses high the next cycle; drop_cnt +1.
REQ-019 in_valid while in_full SHALL not be stored; drop_cnt +1; misroute check takes priority for the pulse, drop counted once.
REQ-020 in_full SHALL be decoded from registered count only; a pop in the same cycle does not admit a write (no bypass).
REQ-021 FSM states IDLE, SEND; IDLE->SEND when count!=0; SEND->IDLE on handshake when count==1 and no write that cycle; otherwise stay in SEND.
REQ-022 link_valid SHALL equal (state==SEND); link_data SHALL equal buffer[rd_ptr] and remain stable while link_valid && !link_ready.
REQ-023 Handshake (link_valid && link_ready) SHALL increment rd_ptr (mod DEPTH), decrement count, increment tx_cnt.
REQ-024 Simultaneous write and handshake SHALL leave count unchanged; both pointers advance.
REQ-025 Latency: write accepted at edge k -> link_valid high after edge k+1 when buffer was empty.
REQ-026 stall counter SHALL increment each SEND cycle with link_ready low, clear on handshake or IDLE; stall_err high while counter==TIMEOUT (counter holds there), cleared by the next handshake.
REQ-027 count SHALL never exceed DEPTH nor go below 0; link_valid never asserts with count==0.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, wr_ptr/rd_ptr/count/stall counter 0, link_valid 0, in_full 0, misroute_err 0, stall_err 0, drop_cnt 0, tx_cnt 0; buffer contents are don't-care.
REQ-029 Reset asserted mid-SEND SHALL discard buffered packets; no link_valid after release until a new write.

Verification
REQ-030 PORT_ID=2, write 0x5A14 with link_ready=1 -> link_valid high after edge 2, link_data=0x5A14, tx_cnt=1, back to IDLE.
REQ-031 link_ready=0, write 5 target-valid packets back to back -> first 4 stored, in_full=1, drop_cnt=1; then ready=1 -> 4 packets out in order, tx_cnt=4.
REQ-032 PORT_ID=2, write 0x0011 -> misroute_err one-cycle pulse, drop_cnt=1, link_valid stays 0.
REQ-033 One packet, link_ready=0 for 16 cycles -> stall_err=1, link_data stable; ready=1 -> handshake, stall_err=0.
REQ-034 Full buffer, write and handshake in same cycle -> write dropped (drop_cnt+1), count=3.
REQ-035 rst_n pulsed low with 3 packets buffered in SEND -> all outputs reset asynchronously, counters 0, link_valid 0 after release.
